// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, padding, CRC-32 FCS and
// inter-frame gap enforcement, with underrun/oversize/error reporting.
module gmii_tx_framer #(
  parameter int P_PREAMBLE_LEN = 7,
  parameter int P_IFG          = 12,
  parameter int P_MIN_FRAME    = 60,
  parameter int P_MAX_FRAME    = 1514,
  parameter bit P_APPEND_FCS   = 1'b1
) (
  input  logic        i_TxClk,
  input  logic        i_Reset_L,
  input  logic [7:0]  i8_Data,
  input  logic        i_Valid,
  input  logic        i_Last,
  input  logic        i_Err,
  output logic        o_Ready,
  output logic [7:0]  o8_TxD,
  output logic        o_TxEN,
  output logic        o_TxER,
  output logic        o_Busy,
  output logic [15:0] o16_FrameCnt,
  output logic [15:0] o16_ErrCnt
);
  // state | meaning (octet loaded at the next edge)
  // IDLE  | line idle, waiting for i_Valid
  // PRE   | 0x55 preamble octets
  // SFD   | 0xD5 start-of-frame delimiter
  // DATA  | user octets, or the 0xFF error octet
  // PAD   | 0x00 pad up to the minimum frame length
  // FCS   | inverted CRC, LSB octet first
  // DROP  | line idle, discarding input to i_Last
  // IFG   | line idle for the inter-frame gap
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
  } state_t;

  localparam logic [15:0] LP_MIN     = 16'(P_MIN_FRAME);
  localparam logic [15:0] LP_MAX     = 16'(P_MAX_FRAME);
  localparam logic [7:0]  LP_PRE_TMR = 8'(P_PREAMBLE_LEN - 1);
  localparam logic [7:0]  LP_IFG_TMR = 8'(P_IFG - 1);

  state_t      r_state, w_state_nxt, w_after_pad;
  logic [7:0]  r_tmr;
  logic [15:0] r_cnt, w_cnt_inc;
  logic [31:0] r_crc;
  logic        r_err;
  logic [7:0]  r_txd, w_txd_nxt;
  logic        r_txen, w_txen_nxt, r_txer, w_txer_nxt;
  logic [15:0] r_frame_cnt, r_err_cnt;
  logic        w_oversize, w_bad_cycle, w_send, w_err_now, w_enter_ifg;

  function automatic logic [31:0] f_crc_byte(input logic [31:0] i_crc, input logic [7:0] i_byte);
    logic [31:0] v_c;
    v_c = i_crc ^ {24'h0, i_byte};
    for (int k = 0; k < 8; k++)
      v_c = v_c[0] ? ((v_c >> 1) ^ 32'hEDB8_8320) : (v_c >> 1);
    return v_c;
  endfunction

  assign w_after_pad = P_APPEND_FCS ? S_FCS : S_IFG;
  assign w_cnt_inc   = r_cnt + 16'd1;
  assign w_oversize  = (r_state == S_DATA) && i_Valid && (r_cnt == LP_MAX);
  assign w_bad_cycle = (r_state == S_DATA) && (!i_Valid || w_oversize);
  assign w_send      = (r_state == S_DATA) && i_Valid && !w_oversize;
  assign w_err_now   = r_err || w_bad_cycle || (w_send && i_Err);
  assign w_enter_ifg = (w_state_nxt == S_IFG) && (r_state != S_IFG);

  assign o_Ready      = (r_state == S_DATA) || (r_state == S_DROP);
  assign o_Busy       = (r_state != S_IDLE);
  assign o8_TxD       = r_txd;
  assign o_TxEN       = r_txen;
  assign o_TxER       = r_txer;
  assign o16_FrameCnt = r_frame_cnt;
  assign o16_ErrCnt   = r_err_cnt;

  always_ff @(posedge i_TxClk or negedge i_Reset_L) begin
    if (!i_Reset_L) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_Valid) w_state_nxt = S_PRE;
      S_PRE:  if (r_tmr == 8'd0) w_state_nxt = S_SFD;
      S_SFD:  w_state_nxt = S_DATA;
      S_DATA: begin
        if (!i_Valid)        w_state_nxt = S_DROP;
        else if (w_oversize) w_state_nxt = i_Last ? S_IFG : S_DROP;
        else if (i_Last)     w_state_nxt = (w_cnt_inc < LP_MIN) ? S_PAD : w_after_pad;
      end
      S_PAD:  if (w_cnt_inc == LP_MIN) w_state_nxt = w_after_pad;
      S_FCS:  if (r_tmr == 8'd0) w_state_nxt = S_IFG;
      S_DROP: if (i_Valid && i_Last) w_state_nxt = S_IFG;
      S_IFG:  if (r_tmr == 8'd0) w_state_nxt = i_Valid ? S_PRE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd_nxt  = 8'h00;
    w_txen_nxt = 1'b0;
    w_txer_nxt = 1'b0;
    case (r_state)
      S_PRE: begin w_txd_nxt = 8'h55; w_txen_nxt = 1'b1; end
      S_SFD: begin w_txd_nxt = 8'hD5; w_txen_nxt = 1'b1; end
      S_DATA: begin
        w_txen_nxt = 1'b1;
        if (w_bad_cycle) begin
          w_txd_nxt  = 8'hFF;
          w_txer_nxt = 1'b1;
        end else begin
          w_txd_nxt  = i8_Data;
          w_txer_nxt = i_Err;
        end
      end
      S_PAD: w_txen_nxt = 1'b1;
      S_FCS: begin w_txd_nxt = ~r_crc[7:0]; w_txen_nxt = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge i_TxClk or negedge i_Reset_L) begin
    if (!i_Reset_L) begin
      r_tmr       <= 8'd0;
      r_cnt       <= 16'd0;
      r_crc       <= 32'hFFFF_FFFF;
      r_err       <= 1'b0;
      r_txd       <= 8'h00;
      r_txen      <= 1'b0;
      r_txer      <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      r_txd  <= w_txd_nxt;
      r_txen <= w_txen_nxt;
      r_txer <= w_txer_nxt;

      // Timer is reloaded on every state change and counts down to zero.
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          S_PRE:   r_tmr <= LP_PRE_TMR;
          S_FCS:   r_tmr <= 8'd3;
          S_IFG:   r_tmr <= LP_IFG_TMR;
          default: r_tmr <= 8'd0;
        endcase
      end else if (r_tmr != 8'd0) begin
        r_tmr <= r_tmr - 8'd1;
      end

      case (r_state)
        S_SFD: begin
          r_crc <= 32'hFFFF_FFFF;
          r_cnt <= 16'd0;
          r_err <= 1'b0;
        end
        S_DATA: begin
          if (w_send) begin
            r_crc <= f_crc_byte(r_crc, i8_Data);
            r_cnt <= w_cnt_inc;
          end
          if (w_err_now) r_err <= 1'b1;
        end
        S_PAD: begin
          r_crc <= f_crc_byte(r_crc, 8'h00);
          r_cnt <= w_cnt_inc;
        end
        S_FCS: r_crc <= {8'hFF, r_crc[31:8]};
        default: ;
      endcase

      if (w_enter_ifg) begin
        if (w_err_now) r_err_cnt   <= r_err_cnt + 16'd1;
        else           r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: the driver queues expected GMII octets
// and frame shapes, a negedge monitor pops and compares them as they appear.
module tb_gmii_tx_framer;
  localparam int P_PRE = 7;
  localparam int P_IFG = 12;
  localparam int P_MIN = 60;
  localparam int P_MAX = 1514;

  logic        i_TxClk, i_Reset_L;
  logic [7:0]  i8_Data;
  logic        i_Valid, i_Last, i_Err;
  logic        o_Ready, o_TxEN, o_TxER, o_Busy;
  logic [7:0]  o8_TxD;
  logic [15:0] o16_FrameCnt, o16_ErrCnt;

  gmii_tx_framer #(
    .P_PREAMBLE_LEN(P_PRE), .P_IFG(P_IFG), .P_MIN_FRAME(P_MIN),
    .P_MAX_FRAME(P_MAX), .P_APPEND_FCS(1'b1)
  ) dut (
    .i_TxClk(i_TxClk), .i_Reset_L(i_Reset_L), .i8_Data(i8_Data),
    .i_Valid(i_Valid), .i_Last(i_Last), .i_Err(i_Err), .o_Ready(o_Ready),
    .o8_TxD(o8_TxD), .o_TxEN(o_TxEN), .o_TxER(o_TxER), .o_Busy(o_Busy),
    .o16_FrameCnt(o16_FrameCnt), .o16_ErrCnt(o16_ErrCnt)
  );

  initial i_TxClk = 1'b0;
  always #4 i_TxClk = ~i_TxClk;

  typedef struct { logic [7:0] d; logic er; } oct_t;
  typedef struct { int len; int gap; } frm_t;
  oct_t q[$];
  frm_t fq[$];
  int n_vec = 0, n_miss = 0;
  int exp_frame = 0, exp_err = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] b);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = b[31-k];
    return r;
  endfunction

  // Non-reflected MSB-first CRC-32 on bit-reversed octets; FCS = ~rev32(reg).
  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {rev8(b), 24'h0};
    for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    return c;
  endfunction

  task automatic push_oct(input logic [7:0] d, input logic er);
    oct_t o;
    o.d = d; o.er = er;
    q.push_back(o);
  endtask

  task automatic put(input logic [7:0] d, input logic l, input logic e);
    bit acc;
    int guard;
    @(negedge i_TxClk);
    i8_Data = d; i_Last = l; i_Err = e; i_Valid = 1'b1;
    guard = 0;
    forever begin
      acc = o_Ready;
      @(posedge i_TxClk);
      if (acc) break;
      guard++;
      if (guard > 4000) begin
        $display("FAIL put_timeout: o_Ready low for %0d cycles, expected high within 4000", guard);
        $fatal(1, "stalled");
      end
      @(negedge i_TxClk);
    end
  endtask

  task automatic send(input int n, input int err_idx, input int und_at, input int gap, input bit keep);
    frm_t f;
    logic [31:0] c, fcs;
    logic [7:0] d;
    bit bad;
    c = 32'hFFFF_FFFF;
    bad = 1'b0;
    f.gap = gap;
    if (und_at >= 0)  f.len = P_PRE + 1 + und_at + 1;
    else if (n > P_MAX) f.len = P_PRE + 1 + P_MAX + 1;
    else              f.len = P_PRE + 1 + ((n < P_MIN) ? P_MIN : n) + 4;
    fq.push_back(f);
    for (int i = 0; i < P_PRE; i++) push_oct(8'h55, 1'b0);
    push_oct(8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = i[7:0];
      if (i == und_at) begin
        push_oct(8'hFF, 1'b1);
        @(negedge i_TxClk);
        i_Valid = 1'b0;
        @(posedge i_TxClk);
        bad = 1'b1;
      end
      if (!bad) begin
        if (i == P_MAX) begin
          push_oct(8'hFF, 1'b1);
          bad = 1'b1;
        end else begin
          push_oct(d, i == err_idx);
          c = crc_next(c, d);
        end
      end
      put(d, i == n - 1, i == err_idx);
    end
    if (!bad) begin
      for (int i = n; i < P_MIN; i++) begin
        push_oct(8'h00, 1'b0);
        c = crc_next(c, 8'h00);
      end
      fcs = ~rev32(c);
      for (int k = 0; k < 4; k++) push_oct(fcs[8*k +: 8], 1'b0);
    end
    if (bad || (err_idx >= 0 && err_idx < n)) exp_err++;
    else exp_frame++;
    if (!keep) begin
      @(negedge i_TxClk);
      i_Valid = 1'b0; i_Last = 1'b0; i_Err = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    do begin
      @(negedge i_TxClk);
      guard++;
    end while ((o_Busy || q.size() != 0) && guard < 3000);
    chk({nm, "_idle_timeout"}, (guard < 3000) ? 1 : 0, 1);
    chk({nm, "_leftover_octets"}, q.size(), 0);
    chk({nm, "_frame_cnt"}, int'(o16_FrameCnt), exp_frame);
    chk({nm, "_err_cnt"}, int'(o16_ErrCnt), exp_err);
  endtask

  // Monitor
  initial begin
    frm_t cur;
    oct_t e;
    int run, gap;
    bit active;
    active = 1'b0; run = 0; gap = 0;
    cur.len = 0; cur.gap = -1;
    forever begin
      @(negedge i_TxClk);
      if (!i_Reset_L) begin
        active = 1'b0;
        gap = 0;
      end else if (o_TxEN) begin
        if (!active) begin
          active = 1'b1;
          run = 0;
          if (fq.size() == 0) begin
            cur.len = -1; cur.gap = -1;
            n_vec++; n_miss++;
            $display("FAIL frame_start: unexpected TxEN rise at %0t, expected none", $time);
          end else begin
            cur = fq.pop_front();
            if (cur.gap >= 0) chk("ifg_gap", gap, cur.gap);
          end
        end
        run++;
        if (q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL octet: got TxD=0x%0h with nothing expected at %0t", o8_TxD, $time);
        end else begin
          e = q.pop_front();
          chk("txd", int'(o8_TxD), int'(e.d));
          chk("txer", int'(o_TxER), int'(e.er));
        end
      end else begin
        if (active) begin
          active = 1'b0;
          if (cur.len >= 0) chk("txen_len", run, cur.len);
          gap = 0;
        end
        gap++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "timeout");
  end

  initial begin
    i_Reset_L = 1'b0;
    i8_Data = 8'h00; i_Valid = 1'b0; i_Last = 1'b0; i_Err = 1'b0;
    #1;
    chk("rst_txen", int'(o_TxEN), 0);
    chk("rst_txd", int'(o8_TxD), 0);
    chk("rst_busy", int'(o_Busy), 0);
    chk("rst_frame_cnt", int'(o16_FrameCnt), 0);
    repeat (3) @(negedge i_TxClk);
    i_Reset_L = 1'b1;
    repeat (2) @(negedge i_TxClk);

    send(100, -1, -1, -1, 1'b0);
    wait_idle("f100");
    send(10, -1, -1, -1, 1'b0);
    wait_idle("f10");
    send(64, -1, -1, -1, 1'b1);
    send(64, -1, -1, P_IFG, 1'b0);
    wait_idle("b2b");
    send(100, -1, 20, -1, 1'b0);
    wait_idle("underrun");
    send(64, 5, -1, -1, 1'b0);
    wait_idle("err5");
    send(1515, -1, -1, -1, 1'b0);
    wait_idle("oversize");

    // Reset mid-frame after data octet 30 has been loaded.
    begin
      frm_t f;
      f.len = -1; f.gap = -1;
      fq.push_back(f);
      for (int i = 0; i < P_PRE; i++) push_oct(8'h55, 1'b0);
      push_oct(8'hD5, 1'b0);
      for (int i = 0; i < 31; i++) begin
        push_oct(i[7:0], 1'b0);
        put(i[7:0], 1'b0, 1'b0);
      end
      #2;
      i_Reset_L = 1'b0;
      i_Valid = 1'b0;
      #1;
      chk("midrst_txen", int'(o_TxEN), 0);
      chk("midrst_txer", int'(o_TxER), 0);
      chk("midrst_txd", int'(o8_TxD), 0);
      chk("midrst_busy", int'(o_Busy), 0);
      chk("midrst_frame_cnt", int'(o16_FrameCnt), 0);
      chk("midrst_err_cnt", int'(o16_ErrCnt), 0);
      q.delete();
      fq.delete();
      exp_frame = 0;
      exp_err = 0;
      repeat (2) @(negedge i_TxClk);
      i_Reset_L = 1'b1;
      repeat (2) @(negedge i_TxClk);
    end

    send(64, -1, -1, -1, 1'b0);
    wait_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
